// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: data width, the canonical
// NOP encoding and the fetch-stage state type.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  // FETCH: a request is outstanding on the instruction-memory port.
  // HOLD:  a returned word is parked in the skid buffer, no request issued.
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

endpackage : mips_pkg

// File: rtl/fetch_if_id_stage_if.sv
// Instruction-memory request/ready port between the fetch stage and memory.
//
// Handshake: the fetch stage raises imem_req with imem_addr; the memory
// completes the request by raising imem_ready for one cycle with the word on
// imem_rdata. A transfer happens on a rising edge where imem_req & imem_ready.
// imem_addr may change while imem_req stays high (a redirect abandons the
// pending request), so the memory must not assume a stable address.
interface fetch_if_id_stage_if;
  import mips_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface : fetch_if_id_stage_if

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and a valid bit.
// flush loads a bubble and beats hold; hold beats load.
module if_id_reg
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc4_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;

  // Next-state selection: flush > hold > load, otherwise keep.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (!hold_i && load_i) begin
      instr_d = instr_i;
      pc4_d   = pc4_i;
      valid_d = 1'b1;
    end
  end

  // Register storage with asynchronous clear to a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule : if_id_reg

// File: rtl/fetch_if_id_stage.sv
// Fetch stage: owns the PC, issues instruction-memory requests, parks a word
// returned during a hold in a skid buffer so it is never lost, and feeds the
// IF/ID register. Redirects override everything, including hold.
module fetch_if_id_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pc_hold,
  input  logic                 if_id_hold,
  input  logic                 redirect,
  input  logic [XLEN-1:0]      redirect_pc,
  fetch_if_id_stage_if.master  imem,
  output logic [XLEN-1:0]      pc_if,
  output logic [XLEN-1:0]      instr_id,
  output logic [XLEN-1:0]      pc4_id,
  output logic                 valid_id,
  output logic                 fetch_stall,
  output fetch_state_t         state_dbg
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] skid_q, skid_d;
  logic            hold;
  logic            load;
  logic            flush;
  logic [XLEN-1:0] load_instr;
  logic [XLEN-1:0] pc_plus4;

  assign hold     = pc_hold | if_id_hold;
  assign pc_plus4 = pc_q + 32'd4;

  // Next state, PC, skid and IF/ID control; redirect wins over every case.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    load       = 1'b0;
    flush      = 1'b0;
    load_instr = imem.imem_rdata;
    if (redirect) begin
      pc_d    = redirect_pc;
      skid_d  = NOP_INSTR;
      flush   = 1'b1;
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem.imem_ready) begin
            if (hold) begin
              skid_d  = imem.imem_rdata;
              state_d = HOLD;
            end else begin
              load = 1'b1;
              pc_d = pc_plus4;
            end
          end else if (!hold) begin
            flush = 1'b1;
          end
        end
        HOLD: begin
          if (!hold) begin
            load_instr = skid_q;
            load       = 1'b1;
            pc_d       = pc_plus4;
            state_d    = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // FSM state, PC and skid buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      skid_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .flush_i (flush),
    .hold_i  (hold),
    .instr_i (load_instr),
    .pc4_i   (pc_plus4),
    .instr_o (instr_id),
    .pc4_o   (pc4_id),
    .valid_o (valid_id)
  );

  // The request is suppressed while reset is asserted.
  assign imem.imem_req  = rst_n && (state_q == FETCH);
  assign imem.imem_addr = pc_q;
  assign fetch_stall    = imem.imem_req & ~imem.imem_ready;
  assign pc_if          = pc_q;
  assign state_dbg      = state_q;

endmodule : fetch_if_id_stage
